// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared parity-mode constants and serialiser state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Byte write handshake, status flags and serial line of the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]          tx_byte;
    logic                          tx_req;
    logic                          tx_busy;
    logic                          tx_idle;
    logic                          tx_overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          tx;

    modport master (
        output tx_byte, tx_req,
        input  tx_busy, tx_idle, tx_overflow, fifo_count, tx
    );

    modport slave (
        input  tx_byte, tx_req,
        output tx_busy, tx_idle, tx_overflow, fifo_count, tx
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);
    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != c_FULL);
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered UART transmitter: FIFO feeding a start/data/parity/stop
//            serialiser with a registered serial output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input wire logic        clk,
    input wire logic        reset,
    uart_tx_fifo_if.slave   bus
);
    localparam int                  c_DIV_W      = $clog2(CLK_DIV);
    localparam int                  c_CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int                  c_BIT_W      = 4;
    localparam int                  c_DIV_LAST_I = CLK_DIV - 1;
    localparam int                  c_DATA_LAST_I = DATA_BITS - 1;
    localparam int                  c_STOP_LAST_I = STOP_BITS - 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_LAST_I[c_DIV_W-1:0];
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST  = c_DATA_LAST_I[c_BIT_W-1:0];
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST  = c_STOP_LAST_I[c_BIT_W-1:0];
    localparam logic                c_HAS_PAR    = (PARITY != PAR_NONE);
    localparam logic                c_ODD        = (PARITY == PAR_ODD);

    tx_state_t              r_state, w_state_nxt;
    logic [c_DIV_W-1:0]     r_div, w_div_nxt;
    logic [c_BIT_W-1:0]     r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic                   r_par, w_par_nxt;
    logic                   r_tx, w_tx_nxt;
    logic                   r_ovf;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_cell_end;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_head;
    logic [c_CNT_W-1:0]     w_count;

    // Acceptance looks only at the registered full flag, never at a same-cycle pop.
    assign w_push = bus.tx_req && !w_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (bus.tx_byte),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_cell_end = (r_div == '0);

    // tx is registered from the value the next state will drive, so the
    // line changes on the same edge as the state.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_load      = 1'b0;
        w_pop       = 1'b0;

        if (r_state != ST_IDLE && !w_cell_end) begin
            w_div_nxt = r_div - 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                w_load   = !w_empty;
            end
            ST_START: begin
                if (w_cell_end) begin
                    w_state_nxt = ST_DATA;
                    w_div_nxt   = c_DIV_LAST;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_cell_end) begin
                    w_div_nxt = c_DIV_LAST;
                    if (r_bit == c_DATA_LAST) begin
                        w_bit_nxt = '0;
                        if (c_HAS_PAR) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_cell_end) begin
                    w_state_nxt = ST_STOP;
                    w_div_nxt   = c_DIV_LAST;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_cell_end) begin
                    if (r_bit == c_STOP_LAST) begin
                        w_load = !w_empty;
                        if (w_empty) begin
                            w_state_nxt = ST_IDLE;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_div_nxt = c_DIV_LAST;
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Loading the FIFO head is shared by IDLE and the last stop cell,
        // which is what makes back-to-back frames gapless.
        if (w_load) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_par_nxt   = (^w_head) ^ c_ODD;
            w_state_nxt = ST_START;
            w_div_nxt   = c_DIV_LAST;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            if (bus.tx_req && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.tx          = r_tx;
    assign bus.tx_busy     = w_full;
    assign bus.tx_idle     = (r_state == ST_IDLE) && w_empty;
    assign bus.tx_overflow = r_ovf;
    assign bus.fifo_count  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo in four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [3:0] req;
    logic [8:0] byt [4];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if2 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4))  if3 ();

    assign if0.tx_byte = byt[0][7:0];
    assign if1.tx_byte = byt[1][7:0];
    assign if2.tx_byte = byt[2][7:0];
    assign if3.tx_byte = byt[3][6:0];
    assign if0.tx_req  = req[0];
    assign if1.tx_req  = req[1];
    assign if2.tx_req  = req[2];
    assign if3.tx_req  = req[3];

    logic [3:0] tx_v;
    logic [3:0] idle_v;
    assign tx_v   = {if3.tx, if2.tx, if1.tx, if0.tx};
    assign idle_v = {if3.tx_idle, if2.tx_idle, if1.tx_idle, if0.tx_idle};

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(16))
        dut0 (.clk(clk), .reset(rst_a), .bus(if0));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(16))
        dut1 (.clk(clk), .reset(rst_b), .bus(if1));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(16))
        dut2 (.clk(clk), .reset(rst_b), .bus(if2));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut3 (.clk(clk), .reset(rst_b), .bus(if3));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] mask, input logic [8:0] data);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                req[i] = 1'b1;
                byt[i] = data;
            end
        end
        step();
        req = req & ~mask;
    endtask

    // Cell k of the frame lasts 4 cycles; bit k of cells is the k-th cell in time.
    function automatic logic [127:0] expand(input logic [63:0] cells, input int n);
        logic [127:0] r = '0;
        for (int k = 0; k < n * 4; k++) begin
            r = r | (128'((cells >> (k / 4)) & 64'd1) << k);
        end
        return r;
    endfunction

    task automatic capture(input logic [1:0] sel, input int len, output logic [127:0] cap);
        cap = '0;
        for (int i = 0; i < len; i++) begin
            cap = cap | (128'(tx_v[sel]) << i);
            step();
        end
    endtask

    logic [7:0] tbl [16] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'hAA, 8'h55, 8'h0F, 8'hF0,
                             8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hEF};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] cap;
        logic [127:0] cap_e;
        logic [127:0] cap_o;

        rst_a = 1'b1;
        rst_b = 1'b1;
        req   = '0;
        for (int i = 0; i < 4; i++) byt[i] = '0;
        req[0] = 1'b1;
        byt[0] = 9'h0AB;
        repeat (3) step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        req   = '0;

        check("rst_tx",    128'(if0.tx), 128'(1));
        check("rst_busy",  128'(if0.tx_busy), 128'(0));
        check("rst_idle",  128'(if0.tx_idle), 128'(1));
        check("rst_ovf",   128'(if0.tx_overflow), 128'(0));
        check("rst_count", 128'(if0.fifo_count), 128'(0));
        step();
        check("rst_req_ignored", 128'({if0.fifo_count, if0.tx_idle, if0.tx}), 128'(3));

        // Single 8N1 frame of 0x55
        write(4'b0001, 9'h055);
        check("t36_n1_tx",   128'(if0.tx), 128'(1));
        check("t36_n1_idle", 128'(if0.tx_idle), 128'(0));
        step();
        capture(2'd0, 40, cap);
        check("t36_frame", cap, expand(64'({1'b1, 8'h55, 1'b0}), 10));
        check("t36_idle_after", 128'(if0.tx_idle), 128'(1));

        // Two consecutive writes become two gapless frames
        write(4'b0001, 9'h0A3);
        write(4'b0001, 9'h03C);
        capture(2'd0, 80, cap);
        check("t39_frames", cap,
              expand(64'({1'b1, 8'h3C, 1'b0, 1'b1, 8'hA3, 1'b0}), 20));
        check("t39_idle_after", 128'(idle_v[0]), 128'(1));

        // Fill the FIFO while a frame is on the line, then overflow once
        write(4'b0001, 9'h0C3);
        step();
        fork
            begin
                for (int f = 0; f < 17; f++) begin
                    logic [7:0] b;
                    capture(2'd0, 40, cap);
                    b = (f == 0) ? 8'hC3 : tbl[f-1];
                    check($sformatf("t38_frame%0d", f), cap, expand(64'({1'b1, b, 1'b0}), 10));
                end
            end
            begin
                step();
                for (int w = 0; w < 17; w++) begin
                    if (w == 0)  check("t38_busy_first", 128'(if0.tx_busy), 128'(0));
                    if (w == 16) begin
                        check("t38_busy_17th",  128'(if0.tx_busy), 128'(1));
                        check("t38_count_full", 128'(if0.fifo_count), 128'(16));
                    end
                    write(4'b0001, (w < 16) ? {1'b0, tbl[w]} : 9'h066);
                end
                check("t38_ovf_set", 128'(if0.tx_overflow), 128'(1));
            end
        join
        check("t38_idle_after", 128'(if0.tx_idle), 128'(1));
        check("t38_ovf_sticky", 128'(if0.tx_overflow), 128'(1));

        // Reset in the middle of the data cells with three entries queued
        write(4'b0001, 9'h05A);
        write(4'b0001, 9'h011);
        write(4'b0001, 9'h022);
        write(4'b0001, 9'h033);
        repeat (3) step();
        check("t41_pre_count", 128'(if0.fifo_count), 128'(3));
        check("t41_pre_tx",    128'(if0.tx), 128'(0));
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("t41_tx",    128'(if0.tx), 128'(1));
        check("t41_count", 128'(if0.fifo_count), 128'(0));
        check("t41_idle",  128'(if0.tx_idle), 128'(1));
        check("t41_ovf",   128'(if0.tx_overflow), 128'(0));
        capture(2'd0, 60, cap);
        check("t41_line_quiet", cap, expand(64'h7FFF, 15));
        check("t41_idle_after", 128'(if0.tx_idle), 128'(1));

        // Even and odd parity of 0x07 (three ones)
        write(4'b0110, 9'h007);
        step();
        fork
            capture(2'd1, 44, cap_e);
            capture(2'd2, 44, cap_o);
        join
        check("t37_even_frame", cap_e, expand(64'({1'b1, 1'b1, 8'h07, 1'b0}), 11));
        check("t37_odd_frame",  cap_o, expand(64'({1'b1, 1'b0, 8'h07, 1'b0}), 11));
        check("t37_idle_after", 128'({idle_v[2], idle_v[1]}), 128'(3));

        // 7 data bits, 2 stop bits
        write(4'b1000, 9'h07F);
        step();
        capture(2'd3, 40, cap);
        check("t40_frame", cap, expand(64'({2'b11, 7'h7F, 1'b0}), 10));
        check("t40_idle_after", 128'(idle_v[3]), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_DIV, 868: clk cycles per bit cell; legal range 2..65535.
REQ-002 Parameter DATA_BITS, 8: payload bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, 0: parity mode; 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, 1: stop bits per frame; legal values 1, 2.
REQ-005 Parameter FIFO_DEPTH, 16: transmit buffer entries; power of two, 2..256.
REQ-006 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port tx_byte, input, DATA_BITS: payload presented with tx_req.
REQ-009 Port tx_req, input, 1: write strobe; one byte per high cycle.
REQ-010 Port tx_busy, output, 1: FIFO full; writes are refused while high.
REQ-011 Port tx_idle, output, 1: FIFO empty and no frame in progress.
REQ-012 Port tx_overflow, output, 1: sticky flag; a write was refused.
REQ-013 Port fifo_count, output, clog2(FIFO_DEPTH)+1: current number of buffered entries.
REQ-014 Port tx, output, 1: serial line; idles high.

Function
REQ-015 Write acceptance: tx_req=1 and fifo_count<FIFO_DEPTH; acceptance depends only on the registered count, even if a pop occurs in the same cycle.
REQ-016 Refused write (tx_req=1 while tx_busy=1): data is discarded and tx_overflow is set until reset.
REQ-017 Simultaneous push and pop: fifo_count is unchanged and both operations complete.
REQ-018 Serialiser FSM states and transitions: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START when the FIFO is non-empty.
REQ-019 IDLE: pops the FIFO head into the shift register whenever fifo_count>0 and moves to START.
REQ-020 Each state holds for CLK_DIV cycles per bit via a down-counter that reloads to CLK_DIV-1 at every bit boundary.
REQ-021 Line value per state: START drives 0; DATA sends DATA_BITS bits LSB first; PARITY is present only if PARITY!=0.
REQ-022 Parity bit value: XOR of the data bits for even parity; its inverse for odd parity.
REQ-023 STOP drives 1 for STOP_BITS x CLK_DIV cycles.
REQ-024 Back-to-back frames: the next start bit immediately follows the last stop cell, with zero idle cycles.
REQ-025 Latency: a byte accepted at cycle N with tx_idle=1 drives tx=0 from cycle N+2.
REQ-026 tx is registered, with no combinational path from inputs to tx.
REQ-027 tx_idle is high only in IDLE with fifo_count=0; it deasserts the cycle after the first accepted write.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; full/empty are derived from fifo_count.
REQ-029 Frame length = CLK_DIV x (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.

Reset
REQ-030 Output reset values: tx=1, tx_busy=0, tx_idle=1, tx_overflow=0, fifo_count=0.
REQ-031 Internal reset: FSM to IDLE, bit and divider counters cleared.
REQ-032 Reset mid-frame: the frame is abandoned, tx=1 on the cycle after reset is sampled, and all FIFO contents are flushed.
REQ-033 tx_req asserted in the same cycle as reset is ignored.

Structure
REQ-034 Shared package uart_pkg: parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN and the FSM state encodings.
REQ-035 Sub-module sync_fifo (parameters WIDTH, DEPTH) implements the buffer; the serialiser FSM stays in uart_tx_fifo.

Verification
REQ-036 CLK_DIV=4, 8N1, write 0x55 when idle -> tx=0 from N+2, then 1,0,1,0,1,0,1,0 then stop 1, each 4 cycles; 40 cycles total; then tx_idle=1.
REQ-037 PARITY=2, write 0x07 -> parity cell=1; PARITY=1, write 0x07 -> parity cell=0; frame length 44 cycles.
REQ-038 FIFO_DEPTH=16, CLK_DIV=4, 17 writes on consecutive cycles while serialising -> the 17th write sees tx_busy=1 and tx_overflow=1; 16 frames emitted with no gaps.
REQ-039 Two writes 0xA3, 0x3C on consecutive cycles -> two frames of 40 cycles each; second start bit starts at cycle 40 after the first start bit.
REQ-040 DATA_BITS=7, STOP_BITS=2, write 0x7F -> 1 start + 7 ones + 2 stop cells.
REQ-041 Reset asserted for 1 cycle mid DATA with 3 entries queued -> tx=1 next cycle, fifo_count=0, tx_idle=1, no further frames.
